// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_driver
// Brief    : Double-buffered, time-multiplexed common-anode 4-digit
//            seven-segment driver with local per-digit blinking.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] codes_in,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);
    localparam logic [19:0]        c_BLANK_FRAME = {4{5'h10}};

    logic [c_REF_W-1:0] r_ref_cnt;
    logic [c_BLK_W-1:0] r_blk_cnt;
    logic               r_phase;
    logic [1:0]         r_index;
    logic [19:0]        r_codes;
    logic [3:0]         r_mask;
    logic               r_prime;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_frame_start;

    logic               w_ref_wrap;
    logic               w_blk_wrap;
    logic               w_load;
    logic [4:0]         w_code;
    logic               w_blank;
    logic [6:0]         w_lut_seg;

    assign w_ref_wrap = (r_ref_cnt == c_REF_LAST);
    assign w_blk_wrap = (r_blk_cnt == c_BLK_LAST);
    // Shadow loads only at a frame boundary so a scan never mixes two frames.
    assign w_load     = r_prime || (w_ref_wrap && (r_index == 2'd3));
    assign w_code     = r_codes[r_index*5 +: 5];
    assign w_blank    = !en || (r_mask[r_index] && !r_phase);

    always_comb begin
        w_lut_seg = 7'h7F;
        case (w_code)
            5'h00: w_lut_seg = 7'h40;
            5'h01: w_lut_seg = 7'h79;
            5'h02: w_lut_seg = 7'h24;
            5'h03: w_lut_seg = 7'h30;
            5'h04: w_lut_seg = 7'h19;
            5'h05: w_lut_seg = 7'h12;
            5'h06: w_lut_seg = 7'h02;
            5'h07: w_lut_seg = 7'h78;
            5'h08: w_lut_seg = 7'h00;
            5'h09: w_lut_seg = 7'h10;
            5'h0A: w_lut_seg = 7'h08;
            5'h0B: w_lut_seg = 7'h03;
            5'h0C: w_lut_seg = 7'h46;
            5'h0D: w_lut_seg = 7'h21;
            5'h0E: w_lut_seg = 7'h06;
            5'h0F: w_lut_seg = 7'h0E;
            5'h11: w_lut_seg = 7'h3F;
            5'h12: w_lut_seg = 7'h47;
            5'h13: w_lut_seg = 7'h0C;
            5'h14: w_lut_seg = 7'h2B;
            5'h15: w_lut_seg = 7'h41;
            default: w_lut_seg = 7'h7F;
        endcase
    end

    // Counters free-run regardless of en so scan and blink stay continuous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt     <= '0;
            r_blk_cnt     <= '0;
            r_phase       <= 1'b1;
            r_index       <= 2'd0;
            r_codes       <= c_BLANK_FRAME;
            r_mask        <= 4'b0000;
            r_prime       <= 1'b1;
            r_an          <= 4'b1111;
            r_seg         <= 7'h7F;
            r_frame_start <= 1'b0;
        end else begin
            r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
            if (w_ref_wrap) begin
                r_index <= r_index + 2'd1;
            end

            r_blk_cnt <= w_blk_wrap ? '0 : r_blk_cnt + 1'b1;
            if (w_blk_wrap) begin
                r_phase <= ~r_phase;
            end

            r_prime       <= 1'b0;
            r_frame_start <= w_load;
            if (w_load) begin
                r_codes <= codes_in;
                r_mask  <= blink_mask;
            end

            r_an  <= en ? ~(4'b0001 << r_index) : 4'b1111;
            r_seg <= w_blank ? 7'h7F : w_lut_seg;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = 1'b1;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_driver
// Brief    : Self-checking bench for ssd_scan_driver (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;

    localparam int c_REF = 4;
    localparam int c_BLK = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [19:0] codes_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    ssd_scan_driver #(
        .REFRESH_DIV (c_REF),
        .BLINK_DIV   (c_BLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .codes_in    (codes_in),
        .blink_mask  (blink_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    typedef struct {
        logic        en;
        logic [19:0] codes;
        logic [3:0]  mask;
        int          cycles;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          k = 1;          // index of the next clock edge since reset release
    logic [19:0] m_codes;
    logic [3:0]  m_mask;

    function automatic logic [6:0] ref_lut(input logic [4:0] c);
        case (c)
            5'h00: return 7'h40;  5'h01: return 7'h79;
            5'h02: return 7'h24;  5'h03: return 7'h30;
            5'h04: return 7'h19;  5'h05: return 7'h12;
            5'h06: return 7'h02;  5'h07: return 7'h78;
            5'h08: return 7'h00;  5'h09: return 7'h10;
            5'h0A: return 7'h08;  5'h0B: return 7'h03;
            5'h0C: return 7'h46;  5'h0D: return 7'h21;
            5'h0E: return 7'h06;  5'h0F: return 7'h0E;
            5'h10: return 7'h7F;  5'h11: return 7'h3F;
            5'h12: return 7'h47;  5'h13: return 7'h0C;
            5'h14: return 7'h2B;  5'h15: return 7'h41;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, got, want, k, $time);
        end
    endtask

    task automatic model_reset();
        k       = 1;
        m_codes = {4{5'h10}};
        m_mask  = 4'b0000;
    endtask

    // Expected outputs after edge k come from closed-form scan/blink timing.
    task automatic tick();
        exp_t       e;
        exp_t       g;
        int         idx;
        logic       ph;
        logic       ld;
        logic [3:0] one;
        one  = 4'b0001;
        idx  = ((k - 1) / c_REF) % 4;
        ph   = (((k - 1) / c_BLK) % 2) == 0;
        ld   = (k == 1) || ((k % (4 * c_REF)) == 0);
        e.an = en ? ~(one << idx) : 4'b1111;
        if (!en || (m_mask[idx] && !ph))
            e.seg = 7'h7F;
        else
            e.seg = ref_lut(m_codes[idx*5 +: 5]);
        e.dp = 1'b1;
        e.fs = ld;
        if (ld) begin
            m_codes = codes_in;
            m_mask  = blink_mask;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 7'd1, 7'd0);
        end else begin
            g = sb.pop_front();
            check("an", {3'b0, an}, {3'b0, g.an});
            check("seg", seg, g.seg);
            check("dp", {6'b0, dp}, {6'b0, g.dp});
            check("frame_start", {6'b0, frame_start}, {6'b0, g.fs});
        end
        k++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, {3'b0, an}, 7'h0F);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_dp"}, {6'b0, dp}, 7'h01);
        check({tag, "_fs"}, {6'b0, frame_start}, 7'h00);
    endtask

    initial begin
        // Scan, mid-frame change, blink, enable gap, blank/dash codes.
        vecs.push_back('{1'b1, {5'h12, 5'h01, 5'h02, 5'h03}, 4'b0000, 36});
        vecs.push_back('{1'b1, {5'h10, 5'h10, 5'h10, 5'h08}, 4'b0000, 22});
        vecs.push_back('{1'b1, {5'h10, 5'h10, 5'h10, 5'h0A}, 4'b0001, 64});
        vecs.push_back('{1'b0, {5'h10, 5'h10, 5'h10, 5'h0A}, 4'b0001, 10});
        vecs.push_back('{1'b1, {5'h11, 5'h1F, 5'h10, 5'h0A}, 4'b0000, 40});
        for (int n = 0; n < 8; n++) begin
            logic [4:0] b;
            b = 5'(4 * n);
            vecs.push_back('{1'b1, {b + 5'd3, b + 5'd2, b + 5'd1, b}, 4'(n), 16});
        end

        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        model_reset();
        en         = vecs[0].en;
        codes_in   = vecs[0].codes;
        blink_mask = vecs[0].mask;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[v]) begin
            en         = vecs[v].en;
            codes_in   = vecs[v].codes;
            blink_mask = vecs[v].mask;
            for (int c = 0; c < vecs[v].cycles; c++) tick();
        end

        // Land just after a shadow-load edge so frame_start is high, then reset asynchronously.
        en = 1'b1;
        while ((k % (4 * c_REF)) != 1) tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        codes_in   = {5'h15, 5'h14, 5'h13, 5'h11};
        blink_mask = 4'b0000;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 24; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
